// File: rtl/ps2_pkg.sv
// Shared PS/2 host transmitter types: FSM state encoding, clock filter width,
// transmit frame layout and common keyboard command bytes.
package ps2_pkg;

    localparam int unsigned FILT_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_REQ       = 3'd2,
        ST_SHIFT     = 3'd3,
        ST_ACK       = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } ps2_tx_state_e;

    // Bits leave LSB-first, so parity sits above the data byte.
    typedef struct packed {
        logic       parity;
        logic [7:0] data;
    } ps2_frame_t;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_ECHO     = 8'hEE;
    localparam logic [7:0] CMD_RESET    = 8'hFF;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// Glitch filter for the PS/2 clock line with a registered falling-edge tick.
module ps2_clk_filter
    import ps2_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic ps2c_in,
    output logic clk_filt,
    output logic fall_tick
);

    logic [FILT_W-1:0] taps;
    logic              filt_n;

    // Output only changes once every tap agrees; mixed taps hold the last value.
    always_comb begin
        filt_n = clk_filt;
        if (&taps)
            filt_n = 1'b1;
        else if (~|taps)
            filt_n = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            taps      <= '1;
            clk_filt  <= 1'b1;
            fall_tick <= 1'b0;
        end else begin
            taps      <= {taps[FILT_W-2:0], ps2c_in};
            clk_filt  <= filt_n;
            fall_tick <= clk_filt & ~filt_n;
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter (inhibit, request-to-send, shift, ACK).
// Define PS2_HOST_TX_TIMEOUT_EN to abort when the device stops clocking.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000,
    parameter int unsigned INHIBIT_US  = 100,
    parameter int unsigned TIMEOUT_MS  = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    input  logic       ps2c_in,
    input  logic       ps2d_in,
    output logic       ps2c_drive_low,
    output logic       ps2d_drive_low,
    output logic       tx_busy,
    output logic       tx_done_tick,
    output logic       tx_err_tick,
    output logic       rx_en_out
);

    localparam int unsigned INHIBIT_CYC = CLK_FREQ_HZ / 1_000_000 * INHIBIT_US;
    localparam int unsigned INH_W       = $clog2(INHIBIT_CYC + 1);

    ps2_tx_state_e state_q, state_n;
    logic [INH_W-1:0] inh_cnt_q, inh_cnt_n;
    logic [3:0]       bit_cnt_q, bit_cnt_n;
    logic [8:0]       sh_q, sh_n;
    logic             ack_q, ack_n;
    logic             c_low_n, d_low_n, busy_n, done_n, err_n;
    logic             clk_filt, fall_tick;
    ps2_frame_t       frame;

    ps2_clk_filter u_clk_filter (
        .clk       (clk),
        .reset     (reset),
        .ps2c_in   (ps2c_in),
        .clk_filt  (clk_filt),
        .fall_tick (fall_tick)
    );

`ifdef PS2_HOST_TX_TIMEOUT_EN
    localparam int unsigned TO_CYC = CLK_FREQ_HZ / 1000 * TIMEOUT_MS;
    localparam int unsigned TO_W   = $clog2(TO_CYC + 1);
    logic [TO_W-1:0] to_cnt_q, to_cnt_n;
`endif

    always_comb begin
        frame.data   = tx_data;
        frame.parity = odd_parity(tx_data);
    end

    // Next-state and next-output logic; outputs are registered below.
    always_comb begin
        state_n   = state_q;
        inh_cnt_n = inh_cnt_q;
        bit_cnt_n = bit_cnt_q;
        sh_n      = sh_q;
        ack_n     = ack_q;
        c_low_n   = ps2c_drive_low;
        d_low_n   = ps2d_drive_low;
        busy_n    = tx_busy;
        done_n    = 1'b0;
        err_n     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                c_low_n = 1'b0;
                d_low_n = 1'b0;
                if (tx_start) begin
                    sh_n      = frame;
                    inh_cnt_n = '0;
                    bit_cnt_n = '0;
                    ack_n     = 1'b0;
                    c_low_n   = 1'b1;
                    d_low_n   = (INHIBIT_CYC == 1);
                    busy_n    = 1'b1;
                    state_n   = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                inh_cnt_n = INH_W'(inh_cnt_q + 1'b1);
                if (inh_cnt_q == INH_W'(INHIBIT_CYC - 2))
                    d_low_n = 1'b1;
                if (inh_cnt_q == INH_W'(INHIBIT_CYC - 1)) begin
                    c_low_n = 1'b0;
                    d_low_n = 1'b1;
                    state_n = ST_REQ;
                end
            end
            ST_REQ: begin
                if (fall_tick) begin
                    d_low_n   = ~sh_q[0];
                    sh_n      = {1'b0, sh_q[8:1]};
                    bit_cnt_n = 4'd1;
                    state_n   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (fall_tick) begin
                    if (bit_cnt_q == 4'd9) begin
                        d_low_n = 1'b0;
                        state_n = ST_ACK;
                    end else begin
                        d_low_n   = ~sh_q[0];
                        sh_n      = {1'b0, sh_q[8:1]};
                        bit_cnt_n = 4'(bit_cnt_q + 4'd1);
                    end
                end
            end
            ST_ACK: begin
                d_low_n = 1'b0;
                if (fall_tick) begin
                    ack_n   = ~ps2d_in;
                    err_n   = ps2d_in;
                    state_n = ST_WAIT_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                c_low_n = 1'b0;
                d_low_n = 1'b0;
                if (clk_filt && ps2d_in) begin
                    done_n    = ack_q;
                    ack_n     = 1'b0;
                    busy_n    = 1'b0;
                    bit_cnt_n = '0;
                    sh_n      = '0;
                    state_n   = ST_IDLE;
                end
            end
            default: begin
                c_low_n = 1'b0;
                d_low_n = 1'b0;
                busy_n  = 1'b0;
                state_n = ST_IDLE;
            end
        endcase

`ifdef PS2_HOST_TX_TIMEOUT_EN
        // Watchdog on the device clock; any falling edge restarts it.
        to_cnt_n = '0;
        if (state_q == ST_REQ || state_q == ST_SHIFT || state_q == ST_ACK) begin
            if (!fall_tick) begin
                to_cnt_n = TO_W'(to_cnt_q + 1'b1);
                if (to_cnt_q == TO_W'(TO_CYC - 1)) begin
                    to_cnt_n  = '0;
                    c_low_n   = 1'b0;
                    d_low_n   = 1'b0;
                    busy_n    = 1'b0;
                    ack_n     = 1'b0;
                    err_n     = 1'b1;
                    bit_cnt_n = '0;
                    sh_n      = '0;
                    state_n   = ST_IDLE;
                end
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            inh_cnt_q      <= '0;
            bit_cnt_q      <= '0;
            sh_q           <= '0;
            ack_q          <= 1'b0;
            ps2c_drive_low <= 1'b0;
            ps2d_drive_low <= 1'b0;
            tx_busy        <= 1'b0;
            tx_done_tick   <= 1'b0;
            tx_err_tick    <= 1'b0;
            rx_en_out      <= 1'b1;
        end else begin
            state_q        <= state_n;
            inh_cnt_q      <= inh_cnt_n;
            bit_cnt_q      <= bit_cnt_n;
            sh_q           <= sh_n;
            ack_q          <= ack_n;
            ps2c_drive_low <= c_low_n;
            ps2d_drive_low <= d_low_n;
            tx_busy        <= busy_n;
            tx_done_tick   <= done_n;
            tx_err_tick    <= err_n;
            rx_en_out      <= ~busy_n;
        end
    end

`ifdef PS2_HOST_TX_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset)
            to_cnt_q <= '0;
        else
            to_cnt_q <= to_cnt_n;
    end
`endif

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural PS/2 device and bit/result scoreboards.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int HALF = 30;
    localparam int INH  = 5000;
`ifdef PS2_HOST_TX_TIMEOUT_EN
    localparam int unsigned TB_TO_MS = 1;
`else
    localparam int unsigned TB_TO_MS = 15;
`endif
    localparam int TO_CYC = 50_000 * TB_TO_MS;

    logic       clk = 1'b0;
    logic       reset;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       dev_clk;
    logic       dev_data;
    logic       ps2c_in, ps2d_in;
    logic       ps2c_drive_low, ps2d_drive_low;
    logic       tx_busy, tx_done_tick, tx_err_tick, rx_en_out;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    logic exp_bits[$];
    logic exp_res[$];

    always #5 clk = ~clk;

    assign ps2c_in = ~ps2c_drive_low & dev_clk;
    assign ps2d_in = ~ps2d_drive_low & dev_data;

    ps2_host_tx #(
        .CLK_FREQ_HZ (50_000_000),
        .INHIBIT_US  (100),
        .TIMEOUT_MS  (TB_TO_MS)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .tx_start       (tx_start),
        .tx_data        (tx_data),
        .ps2c_in        (ps2c_in),
        .ps2d_in        (ps2d_in),
        .ps2c_drive_low (ps2c_drive_low),
        .ps2d_drive_low (ps2d_drive_low),
        .tx_busy        (tx_busy),
        .tx_done_tick   (tx_done_tick),
        .tx_err_tick    (tx_err_tick),
        .rx_en_out      (rx_en_out)
    );

    always @(posedge clk) begin
        if (tx_done_tick) done_cnt <= done_cnt + 1;
        if (tx_err_tick)  err_cnt  <= err_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One host transfer against the device model. stop_edge>0 stops clocking
    // after that edge, rst_edge>0 resets the DUT in that edge's low phase,
    // inject pulses tx_start=0x55 during edge 3.
    task automatic send(input logic [7:0] d, input bit ack, input int stop_edge,
                        input int rst_edge, input bit inject);
        int   n;
        int   d0, e0;
        logic last_d;
        logic ebit;
        logic r;
        for (int i = 0; i < 8; i++) exp_bits.push_back(d[i]);
        exp_bits.push_back(~^d);
        exp_bits.push_back(1'b1);
        if (rst_edge == 0) exp_res.push_back((stop_edge == 0) ? ack : 1'b0);
        d0 = done_cnt;
        e0 = err_cnt;

        @(negedge clk);
        tx_data  = d;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        tx_data  = 8'h00;
        check("busy_after_start", 32'(tx_busy), 32'd1);
        check("rx_en_during_tx", 32'(rx_en_out), 32'd0);

        n = 0;
        last_d = 1'b0;
        while (ps2c_drive_low === 1'b1 && n < INH + 100) begin
            last_d = ps2d_drive_low;
            n++;
            @(negedge clk);
        end
        check("inhibit_len", 32'(n), 32'(INH));
        check("data_low_last_inhibit", 32'(last_d), 32'd1);
        check("start_bit", 32'(ps2d_in), 32'd0);
        wait_cycles(10);

        for (int e = 1; e <= 11; e++) begin
            if (e == 11) dev_data = ack ? 1'b0 : 1'b1;
            dev_clk = 1'b0;
            if (inject && e == 3) begin
                @(negedge clk);
                tx_data  = 8'h55;
                tx_start = 1'b1;
                @(negedge clk);
                tx_start = 1'b0;
                tx_data  = 8'h00;
                wait_cycles(HALF - 2);
            end else begin
                wait_cycles(HALF);
            end
            if (e == rst_edge) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                check("rst_clk_released", 32'(ps2c_drive_low), 32'd0);
                check("rst_data_released", 32'(ps2d_drive_low), 32'd0);
                check("rst_busy", 32'(tx_busy), 32'd0);
                check("rst_no_done", 32'(done_cnt - d0), 32'd0);
                check("rst_no_err", 32'(err_cnt - e0), 32'd0);
                dev_clk = 1'b1;
                exp_bits.delete();
                wait_cycles(20);
                return;
            end
            if (e <= 10) begin
                if (exp_bits.size() == 0) begin
                    tests++;
                    fails++;
                    $error("FAIL scoreboard_empty: observed 0 entries expected 1");
                end else begin
                    ebit = exp_bits.pop_front();
                    check($sformatf("bit%0d", e), 32'(ps2d_in), 32'(ebit));
                end
            end
            dev_clk = 1'b1;
            wait_cycles(HALF);
            if (e == 11) dev_data = 1'b1;
            if (e == stop_edge) begin
                exp_bits.delete();
                break;
            end
        end

        n = 0;
        while (tx_busy === 1'b1 && n < ((stop_edge != 0) ? TO_CYC + 2000 : 2000)) begin
            n++;
            @(negedge clk);
        end
        check("return_idle", 32'(tx_busy), 32'd0);
        check("clk_released_end", 32'(ps2c_drive_low), 32'd0);
        check("data_released_end", 32'(ps2d_drive_low), 32'd0);
        wait_cycles(3);
        r = exp_res.pop_front();
        check("done_ticks", 32'(done_cnt - d0), r ? 32'd1 : 32'd0);
        check("err_ticks", 32'(err_cnt - e0), r ? 32'd0 : 32'd1);
        check("rx_en_idle", 32'(rx_en_out), 32'd1);
        check("idle_after", 32'(tx_busy), 32'd0);
    endtask

    initial begin
        reset    = 1'b1;
        tx_start = 1'b0;
        tx_data  = 8'h00;
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        wait_cycles(5);
        check("reset_clk_drive", 32'(ps2c_drive_low), 32'd0);
        check("reset_data_drive", 32'(ps2d_drive_low), 32'd0);
        check("reset_busy", 32'(tx_busy), 32'd0);
        check("reset_done", 32'(tx_done_tick), 32'd0);
        check("reset_err", 32'(tx_err_tick), 32'd0);
        check("reset_rx_en", 32'(rx_en_out), 32'd1);
        reset = 1'b0;
        wait_cycles(20);

        send(CMD_SET_LEDS, 1'b1, 0, 0, 1'b0);
        send(8'h07, 1'b1, 0, 0, 1'b0);
        send(8'h00, 1'b1, 0, 0, 1'b0);
        send(CMD_ECHO, 1'b0, 0, 0, 1'b0);
        send(CMD_SET_LEDS, 1'b1, 0, 0, 1'b1);

        @(negedge clk);
        reset    = 1'b1;
        tx_start = 1'b1;
        tx_data  = CMD_RESET;
        @(negedge clk);
        reset    = 1'b0;
        tx_start = 1'b0;
        check("rst_wins_busy", 32'(tx_busy), 32'd0);
        @(negedge clk);
        check("rst_wins_no_inhibit", 32'(ps2c_drive_low), 32'd0);
        check("rst_wins_still_idle", 32'(tx_busy), 32'd0);
        wait_cycles(20);

        send(CMD_RESET, 1'b1, 0, 6, 1'b0);
        send(CMD_RESET, 1'b1, 0, 0, 1'b0);
`ifdef PS2_HOST_TX_TIMEOUT_EN
        send(CMD_SET_LEDS, 1'b1, 4, 0, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
